// File: rtl/const_load_ctrl_pkg.sv
// Shared types for the constant-load sequencer.
// Op encodings and FSM state enum.
package const_ctrl_pkg;

    localparam logic [1:0] FMT_PASS  = 2'b01;
    localparam logic [1:0] FMT_MERGE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAP,
        EXEC,
        WB,
        ERR
    } cl_state_t;

endpackage

// File: rtl/const_load_ctrl_if.sv
// Bus bundle between the constant-load sequencer and
// decode, register file, constant ALU and write-back arbiter.
interface const_load_ctrl_if #(
    parameter int W      = 16,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_formato;
    logic              req_r;
    logic [ADDR_W-1:0] req_rd;
    logic [W-1:0]      req_const;

    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [W-1:0]      rf_rd_data;

    logic [W-1:0]      ula_dado;
    logic [W-1:0]      ula_constante;
    logic [1:0]        ula_formato;
    logic              ula_r;
    logic [W-1:0]      ula_result;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [W-1:0]      wb_data;

    logic              done;
    logic              err;
    logic              busy;

    modport master (
        input  req_valid, req_formato, req_r, req_rd, req_const,
        input  rf_rd_data, ula_result, wb_ready,
        output req_ready, rf_rd_en, rf_rd_addr,
        output ula_dado, ula_constante, ula_formato, ula_r,
        output wb_valid, wb_addr, wb_data,
        output done, err, busy
    );

    modport slave (
        output req_valid, req_formato, req_r, req_rd, req_const,
        output rf_rd_data, ula_result, wb_ready,
        input  req_ready, rf_rd_en, rf_rd_addr,
        input  ula_dado, ula_constante, ula_formato, ula_r,
        input  wb_valid, wb_addr, wb_data,
        input  done, err, busy
    );

endinterface

// File: rtl/const_load_ctrl.sv
// Sequencer for the constant ALU: pass or byte-merge a
// constant into a register and write it back via the RF port.
module const_load_ctrl
    import const_ctrl_pkg::*;
#(
    parameter int W      = 16,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    const_load_ctrl_if.master bus
);

    cl_state_t         state_q;
    cl_state_t         state_d;

    logic [1:0]        fmt_q;
    logic              r_q;
    logic [ADDR_W-1:0] rd_q;
    logic [W-1:0]      const_q;

    logic [W-1:0]      dado_q;
    logic [W-1:0]      cnst_q;
    logic [1:0]        ufmt_q;
    logic              ur_q;
    logic [W-1:0]      wbd_q;
    logic              done_q;

    logic              accept;
    logic              wb_hs;

    logic              ready_c;
    logic              rd_en_c;
    logic              wb_valid_c;
    logic              err_c;
    logic              busy_c;

    assign accept = bus.req_valid && (state_q == IDLE);
    assign wb_hs  = (state_q == WB) && bus.wb_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        state_d    = state_q;
        ready_c    = 1'b0;
        rd_en_c    = 1'b0;
        wb_valid_c = 1'b0;
        err_c      = 1'b0;
        busy_c     = 1'b1;
        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (bus.req_valid) begin
                    case (bus.req_formato)
                        FMT_MERGE: state_d = READ;
                        FMT_PASS:  state_d = EXEC;
                        default:   state_d = ERR;
                    endcase
                end
            end
            READ: begin
                rd_en_c = 1'b1;
                state_d = CAP;
            end
            CAP:  state_d = EXEC;
            EXEC: state_d = WB;
            WB: begin
                wb_valid_c = 1'b1;
                if (bus.wb_ready) state_d = IDLE;
            end
            ERR: begin
                err_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Op latch, ALU operand staging and result capture.
    // Merge operands only change together with ula_dado on
    // the CAP->EXEC edge, so the ALU never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_q   <= '0;
            r_q     <= 1'b0;
            rd_q    <= '0;
            const_q <= '0;
            dado_q  <= '0;
            cnst_q  <= '0;
            ufmt_q  <= '0;
            ur_q    <= 1'b0;
            wbd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (accept) begin
                fmt_q   <= bus.req_formato;
                r_q     <= bus.req_r;
                rd_q    <= bus.req_rd;
                const_q <= bus.req_const;
            end
            if (accept && (bus.req_formato == FMT_PASS)) begin
                cnst_q <= bus.req_const;
                ufmt_q <= bus.req_formato;
                ur_q   <= bus.req_r;
            end
            if (state_q == CAP) begin
                dado_q <= bus.rf_rd_data;
                cnst_q <= const_q;
                ufmt_q <= fmt_q;
                ur_q   <= r_q;
            end
            if (state_q == EXEC) begin
                wbd_q <= bus.ula_result;
            end
            done_q <= wb_hs;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.rf_rd_en      = rd_en_c;
    assign bus.rf_rd_addr    = rd_q;
    assign bus.ula_dado      = dado_q;
    assign bus.ula_constante = cnst_q;
    assign bus.ula_formato   = ufmt_q;
    assign bus.ula_r         = ur_q;
    assign bus.wb_valid      = wb_valid_c;
    assign bus.wb_addr       = rd_q;
    assign bus.wb_data       = wbd_q;
    assign bus.done          = done_q;
    assign bus.err           = err_c;
    assign bus.busy          = busy_c;

endmodule
